adv_dir_input: RTL and testbench



---
 rtl/adv_dir_input.sv | 115 +++++++++++
 tb/tb_adv_dir_input.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv_dir_input.sv
// Direction-button conditioner for the adventure game: synchronises and debounces four
// raw buttons and issues one registered N/S/E/W move pulse per clean single-button press.
module adv_dir_input #(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n_raw,
    input  logic       btn_s_raw,
    input  logic       btn_e_raw,
    input  logic       btn_w_raw,
    input  logic       halt,
    output logic       N,
    output logic       S,
    output logic       E,
    output logic       W,
    output logic       conflict,
    output logic [7:0] moves
);

    // Handshake: none. Outputs are single-cycle strobes; the consumer samples them every clock.
    typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

    logic [3:0]       raw;      // bit 0 = N, 1 = S, 2 = E, 3 = W
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [CNT_W-1:0] cnt [4];

    state_t     state;
    state_t     state_nxt;
    logic [3:0] move_q;
    logic [3:0] move_nxt;
    logic       conflict_q;
    logic       conflict_nxt;
    logic [7:0] moves_q;
    logic [7:0] moves_nxt;

    assign raw = {btn_w_raw, btn_e_raw, btn_s_raw, btn_n_raw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // d only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        move_nxt     = '0;
        conflict_nxt = 1'b0;
        moves_nxt    = moves_q;
        case (state)
            IDLE: begin
                if (!halt) begin
                    if ($onehot(deb)) begin
                        move_nxt  = deb;
                        state_nxt = FIRE;
                    end else if (deb != 4'b0000) begin
                        conflict_nxt = 1'b1;
                        state_nxt    = HOLD;
                    end
                end
            end
            FIRE: begin
                if (moves_q != 8'hFF) moves_nxt = moves_q + 8'd1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // Re-arm only once every button has been released and debounced low
                if (deb == 4'b0000) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            move_q     <= '0;
            conflict_q <= 1'b0;
            moves_q    <= '0;
        end else begin
            state      <= state_nxt;
            move_q     <= move_nxt;
            conflict_q <= conflict_nxt;
            moves_q    <= moves_nxt;
        end
    end

    assign N        = move_q[0];
    assign S        = move_q[1];
    assign E        = move_q[2];
    assign W        = move_q[3];
    assign conflict = conflict_q;
    assign moves    = moves_q;

endmodule

// File: tb/tb_adv_dir_input.sv
// Bench for adv_dir_input: directed scenarios plus random button traffic, every cycle
// compared against a window-based behavioural model of debounce and press acceptance.
module tb_adv_dir_input;

    localparam int D = 4;

    logic       clk;
    logic       reset_n;
    logic       btn_n_raw, btn_s_raw, btn_e_raw, btn_w_raw;
    logic       halt;
    logic       N, S, E, W, conflict;
    logic [7:0] moves;

    int checks   = 0;
    int failures = 0;

    adv_dir_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_n_raw(btn_n_raw),
        .btn_s_raw(btn_s_raw),
        .btn_e_raw(btn_e_raw),
        .btn_w_raw(btn_w_raw),
        .halt     (halt),
        .N        (N),
        .S        (S),
        .E        (E),
        .W        (W),
        .conflict (conflict),
        .moves    (moves)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // behavioural model: raw sample history per button, debounced levels, press acceptance
    bit         hist_q [4][$];
    bit         m_d    [4];
    int         m_mode;          // 0 armed, 1 pulse issued, 2 waiting for release
    logic [3:0] m_move;
    bit         m_conf;
    int         m_moves;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            hist_q[b].delete();
            for (int k = 0; k < D + 2; k++) hist_q[b].push_back(1'b0);
            m_d[b] = 1'b0;
        end
        m_mode  = 0;
        m_move  = '0;
        m_conf  = 1'b0;
        m_moves = 0;
    endtask

    // A debounced level flips when the last D synchronised samples (raw taken two edges
    // earlier) all disagree with it.
    task automatic model_edge(input logic [3:0] raw, input bit h);
        bit d_new [4];
        int nd;
        int hi;
        bit flip;
        nd = 0;
        hi = 0;
        for (int b = 0; b < 4; b++) begin
            hist_q[b].push_back(raw[b]);
            void'(hist_q[b].pop_front());
            flip = 1'b1;
            for (int k = 0; k < D; k++) if (hist_q[b][k] == m_d[b]) flip = 1'b0;
            d_new[b] = flip ? !m_d[b] : m_d[b];
            if (m_d[b]) begin
                nd++;
                hi = b;
            end
        end
        m_move = '0;
        m_conf = 1'b0;
        if (m_mode == 0) begin
            if (!h && nd == 1) begin
                m_move[hi] = 1'b1;
                m_mode = 1;
            end else if (!h && nd > 1) begin
                m_conf = 1'b1;
                m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (m_moves < 255) m_moves++;
            m_mode = 2;
        end else begin
            if (nd == 0) m_mode = 0;
        end
        for (int b = 0; b < 4; b++) m_d[b] = d_new[b];
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        logic [7:0] mv;
        mv = 8'(m_moves);
        check(tag, {19'd0, N, S, E, W, conflict, moves},
              {19'd0, m_move[0], m_move[1], m_move[2], m_move[3], m_conf, mv});
    endtask

    // driver: one clock edge, model update, output comparison 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge({btn_w_raw, btn_e_raw, btn_s_raw, btn_n_raw}, halt);
        #1;
        check_out("cycle");
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_w_raw, btn_e_raw, btn_s_raw, btn_n_raw} = v;
    endtask

    int first_hit;
    int hit_cnt;
    int other_cnt;
    int n_total;
    bit found;
    int r;
    logic [3:0] pat;

    initial begin
        reset_n = 1'b0;
        halt    = 1'b0;
        set_btns(4'b0000);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, N, S, E, W, conflict, moves}, 32'd0);
        #1 reset_n = 1'b1;
        repeat (3) step();

        // clean East press
        set_btns(4'b0100);
        first_hit = -1; hit_cnt = 0; other_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (E) begin hit_cnt++; if (first_hit < 0) first_hit = k; end
            if (N | S | W | conflict) other_cnt++;
        end
        check("clean_e_latency", first_hit, 6);
        check("clean_e_count", hit_cnt, 1);
        check("clean_e_others", other_cnt, 0);
        check("clean_e_moves", moves, 1);
        set_btns(4'b0000);
        repeat (15) step();

        // bouncing North press
        set_btns(4'b0001); step();
        set_btns(4'b0000); step();
        set_btns(4'b0001); step();
        set_btns(4'b0000); step();
        set_btns(4'b0001);
        first_hit = -1; hit_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (N) begin hit_cnt++; if (first_hit < 0) first_hit = k; end
        end
        check("bounce_n_latency", first_hit, 6);
        check("bounce_n_count", hit_cnt, 1);
        check("bounce_n_moves", moves, 2);
        set_btns(4'b0000);
        repeat (15) step();

        // simultaneous North + West is rejected
        set_btns(4'b1001);
        first_hit = -1; hit_cnt = 0; other_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (conflict) begin hit_cnt++; if (first_hit < 0) first_hit = k; end
            if (N | S | E | W) other_cnt++;
        end
        check("conflict_latency", first_hit, 6);
        check("conflict_count", hit_cnt, 1);
        check("conflict_no_move", other_cnt, 0);
        check("conflict_moves", moves, 2);
        set_btns(4'b0000);
        repeat (15) step();
        set_btns(4'b0010);
        hit_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (S) hit_cnt++;
        end
        check("after_conflict_s", hit_cnt, 1);
        set_btns(4'b0000);
        repeat (15) step();

        // press held through halt fires on the first unhalted edge
        halt = 1'b1;
        set_btns(4'b0010);
        hit_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (N | S | E | W | conflict) hit_cnt++;
        end
        check("halt_suppress", hit_cnt, 0);
        halt = 1'b0;
        step();
        check("halt_release_s", S, 1);
        step();
        check("halt_moves", moves, 4);
        set_btns(4'b0000);
        repeat (15) step();

        // async reset during a West pulse
        set_btns(4'b1000);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (W) found = 1'b1;
        end
        check("reset_mid_w_seen", found, 1);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_mid_w_drop", W, 0);
        check("reset_mid_moves", moves, 0);
        check_out("reset_mid_all");
        @(posedge clk);
        #2 reset_n = 1'b1;
        first_hit = -1;
        for (int k = 0; k < 14; k++) begin
            step();
            if (W && first_hit < 0) first_hit = k;
        end
        check("reset_rearm_w", first_hit, 6);
        set_btns(4'b0000);
        repeat (15) step();

        // saturation of the move counter
        n_total = 0;
        for (int i = 0; i < 260; i++) begin
            set_btns(4'b0001);
            repeat (9) begin
                step();
                if (N) n_total++;
            end
            set_btns(4'b0000);
            repeat (10) step();
            if (i == 254) check("sat_at_255", moves, 255);
        end
        check("sat_pulses", n_total, 260);
        check("sat_final", moves, 255);

        // random traffic, including short glitches, multi-button presses and halt
        for (int seg = 0; seg < 120; seg++) begin
            r = $urandom_range(0, 5);
            if (r < 4) pat = 4'b0001 << r;
            else if (r == 4) pat = 4'b0000;
            else pat = 4'($urandom_range(0, 15));
            set_btns(pat);
            halt = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 10)) step();
        end
        halt = 1'b0;
        set_btns(4'b0000);
        repeat (15) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
